// File: rtl/field_packer_pkg.sv
// Shared widths, pad constant and controller state encoding for the field packer.
package field_packer_pkg;
  localparam int FIELD_W    = 5;
  localparam int NUM_FIELDS = 6;
  localparam int WORD_W     = 32;
  localparam logic [1:0] PAD = 2'b11;
  localparam int BUF_W      = (NUM_FIELDS - 1) * FIELD_W;

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FILL       = 2'd1,
    EMIT       = 2'd2
  } state_t;
endpackage

// File: rtl/field_packer_word_byte_serializer.sv
// Loads a packed 32-bit word and hands it out MSB byte first over a valid/ready handshake.
module word_byte_serializer
  import field_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_out_ready,
  output logic              o_out_valid,
  output logic [7:0]        o_out_byte,
  output logic              o_out_last,
  output logic              o_done
);
  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_bcnt;
  logic              r_valid;
  logic              r_last;
  logic              w_hs;

  assign w_hs = r_valid && i_out_ready;

  // The word is zeroed once drained so the idle byte output reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_bcnt  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_clear) begin
      r_word  <= '0;
      r_bcnt  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_bcnt  <= '0;
      r_valid <= 1'b1;
      r_last  <= 1'b0;
    end else if (w_hs) begin
      if (r_bcnt == 2'd3) begin
        r_word  <= '0;
        r_bcnt  <= '0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_word <= {r_word[WORD_W-9:0], 8'h00};
        r_bcnt <= r_bcnt + 2'd1;
        r_last <= (r_bcnt == 2'd2);
      end
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_byte  = r_word[WORD_W-1:WORD_W-8];
  assign o_out_last  = r_last;
  assign o_done      = w_hs && (r_bcnt == 2'd3) && !i_clear;
endmodule

// File: rtl/field_packer_ctrl.sv
// Collects six 5-bit fields into a padded 32-bit word and streams it out as four bytes.
module field_packer_ctrl
  import field_packer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [FIELD_W-1:0] i_in_field,
  input  logic               i_abort,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [7:0]         o_out_byte,
  output logic               o_out_last,
  output logic [7:0]         o_frame_cnt
);
  state_t            r_state;
  state_t            w_next_state;
  logic [2:0]        r_fcnt;
  logic [BUF_W-1:0]  r_buf;
  logic              r_in_ready;
  logic [7:0]        r_frame_cnt;
  logic              w_accept;
  logic              w_load;
  logic              w_done;
  logic [WORD_W-1:0] w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RESET_HOLD;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      RESET_HOLD: w_next_state = FILL;
      FILL: begin
        if (i_abort)     w_next_state = FILL;
        else if (w_load) w_next_state = EMIT;
      end
      EMIT: begin
        if (i_abort || w_done) w_next_state = FILL;
      end
      default: w_next_state = RESET_HOLD;
    endcase
  end

  // in_ready is a flop that mirrors the FILL state; abort wins over any handshake.
  always_comb begin
    w_accept = i_in_valid && r_in_ready && !i_abort;
    w_load   = w_accept && (r_fcnt == 3'(NUM_FIELDS - 1));
    w_word   = {r_buf, i_in_field, PAD};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_fcnt      <= '0;
      r_buf       <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_in_ready <= (w_next_state == FILL);
      if (i_abort) begin
        r_fcnt <= '0;
        r_buf  <= '0;
      end else if (w_accept) begin
        if (w_load) begin
          r_fcnt <= '0;
          r_buf  <= '0;
        end else begin
          r_fcnt <= r_fcnt + 3'd1;
          r_buf  <= {r_buf[BUF_W-FIELD_W-1:0], i_in_field};
        end
      end
      if (w_done) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  word_byte_serializer u_serializer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_clear     (i_abort),
    .i_word      (w_word),
    .i_out_ready (i_out_ready),
    .o_out_valid (o_out_valid),
    .o_out_byte  (o_out_byte),
    .o_out_last  (o_out_last),
    .o_done      (w_done)
  );

  assign o_in_ready  = r_in_ready;
  assign o_frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_field_packer_ctrl.sv
// Bench for field_packer_ctrl: frame-level reference model checked every cycle plus directed literals.
module tb_field_packer_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       inValid = 1'b0;
  logic [4:0] inField = 5'd0;
  logic       abortIn = 1'b0;
  logic       outReady = 1'b0;
  logic       inReady;
  logic       outValid;
  logic [7:0] outByte;
  logic       outLast;
  logic [7:0] frameCnt;

  int checks = 0;
  int errors = 0;

  logic [4:0] fIncr  [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
  logic [4:0] fOnes  [6] = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
  logic [4:0] fZeros [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
  logic [7:0] expIncr [4] = '{8'h08, 8'h86, 8'h42, 8'h9B};

  always #5 clk = ~clk;

  field_packer_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in_field  (inField),
    .i_abort     (abortIn),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_byte  (outByte),
    .o_out_last  (outLast),
    .o_frame_cnt (frameCnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a frame is a list of fields; once six arrive, the packed word becomes a byte queue.
  logic [4:0] mFields[$];
  logic [7:0] mBytes[$];
  bit         mInReady = 1'b0;
  bit         mOutValid = 1'b0;
  int         mFrames = 0;

  function automatic logic [31:0] packWord(input logic [4:0] f[$]);
    logic [31:0] w;
    w = 32'd3;
    for (int i = 0; i < 6; i++) w = w | (32'(f[i]) << (27 - 5 * i));
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mFields.delete();
      mBytes.delete();
      mInReady  = 1'b0;
      mOutValid = 1'b0;
      mFrames   = 0;
    end else begin
      bit inHs;
      bit outHs;
      logic [31:0] w;
      inHs  = inValid && mInReady;
      outHs = mOutValid && outReady;
      if (abortIn) begin
        mFields.delete();
        mBytes.delete();
        mOutValid = 1'b0;
        mInReady  = 1'b1;
      end else if (!mInReady && !mOutValid) begin
        mInReady = 1'b1;
      end else if (inHs) begin
        mFields.push_back(inField);
        if (mFields.size() == 6) begin
          w = packWord(mFields);
          for (int b = 0; b < 4; b++) mBytes.push_back(8'(w >> (24 - 8 * b)));
          mFields.delete();
          mInReady  = 1'b0;
          mOutValid = 1'b1;
        end
      end else if (outHs) begin
        void'(mBytes.pop_front());
        if (mBytes.size() == 0) begin
          mFrames   = (mFrames + 1) % 256;
          mOutValid = 1'b0;
          mInReady  = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready", {31'd0, inReady}, {31'd0, mInReady});
    checkOutput("out_valid", {31'd0, outValid}, {31'd0, mOutValid});
    checkOutput("out_byte", {24'd0, outByte}, {24'd0, (mOutValid ? mBytes[0] : 8'h00)});
    checkOutput("out_last", {31'd0, outLast}, {31'd0, (mOutValid && mBytes.size() == 1)});
    checkOutput("frame_cnt", {24'd0, frameCnt}, 32'(mFrames % 256));
  end

  // Byte monitor used by the literal checks.
  logic [7:0] gotBytes[$];
  bit         gotLast[$];
  time        lastTimes[$];

  always @(posedge clk) begin
    if (rst_n && outValid && outReady && !abortIn) begin
      gotBytes.push_back(outByte);
      gotLast.push_back(outLast);
      if (outLast) lastTimes.push_back($time);
    end
  end

  task automatic applyStimulus(input bit v, input logic [4:0] f, input bit r, input bit a);
    inValid  = v;
    inField  = f;
    outReady = r;
    abortIn  = a;
    @(posedge clk);
    #2;
  endtask

  task automatic runFrame(input logic [4:0] f [6], input bit toggle);
    int idx = 0;
    int nb = 0;
    int cyc = 0;
    bit rdy = 1'b1;
    bit hs;
    while (idx < 6 && cyc < 50) begin
      hs = inReady;
      applyStimulus(1'b1, f[idx], 1'b1, 1'b0);
      if (hs) idx++;
      cyc++;
    end
    while (nb < 4 && cyc < 100) begin
      hs = outValid && rdy;
      applyStimulus(1'b0, 5'd0, rdy, 1'b0);
      if (hs) nb++;
      if (toggle) rdy = !rdy;
      cyc++;
    end
    inValid  = 1'b0;
    outReady = 1'b0;
    checkOutput("frame_timeout", {31'd0, (idx == 6 && nb == 4)}, 32'd1);
  endtask

  initial begin
    #1;
    rst_n   = 1'b0;
    inValid = 1'b1;
    inField = 5'h07;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_in_ready", {31'd0, inReady}, 32'd0);
    checkOutput("reset_out_byte", {24'd0, outByte}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("in_ready_pre_edge", {31'd0, inReady}, 32'd0);
    @(posedge clk);
    #2;
    inValid = 1'b0;
    checkOutput("in_ready_post_edge", {31'd0, inReady}, 32'd1);

    $display("[TB] incrementing fields, two back-to-back frames");
    gotBytes.delete(); gotLast.delete(); lastTimes.delete();
    runFrame(fIncr, 1'b0);
    checkOutput("frame_cnt_1", {24'd0, frameCnt}, 32'd1);
    runFrame(fIncr, 1'b0);
    checkOutput("byte_count_incr", gotBytes.size(), 32'd8);
    for (int i = 0; i < 4; i++) begin
      checkOutput("incr_byte", {24'd0, gotBytes[i]}, {24'd0, expIncr[i]});
      checkOutput("incr_last", {31'd0, gotLast[i]}, {31'd0, (i == 3)});
    end
    checkOutput("frame_period", 32'(lastTimes[1] - lastTimes[0]), 32'd100);
    checkOutput("frame_cnt_2", {24'd0, frameCnt}, 32'd2);

    $display("[TB] all-ones fields with stalling sink");
    gotBytes.delete(); gotLast.delete();
    runFrame(fOnes, 1'b1);
    checkOutput("byte_count_ones", gotBytes.size(), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("ones_byte", {24'd0, gotBytes[i]}, 32'hFF);
    checkOutput("frame_cnt_3", {24'd0, frameCnt}, 32'd3);

    $display("[TB] abort during fill");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'h0A, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'h0B, 1'b1, 1'b1);
    checkOutput("abort_fill_ready", {31'd0, inReady}, 32'd1);
    gotBytes.delete(); gotLast.delete();
    runFrame(fZeros, 1'b0);
    checkOutput("byte_count_zero", gotBytes.size(), 32'd4);
    checkOutput("zero_byte0", {24'd0, gotBytes[0]}, 32'h00);
    checkOutput("zero_byte1", {24'd0, gotBytes[1]}, 32'h00);
    checkOutput("zero_byte2", {24'd0, gotBytes[2]}, 32'h00);
    checkOutput("zero_byte3", {24'd0, gotBytes[3]}, 32'h03);
    checkOutput("frame_cnt_4", {24'd0, frameCnt}, 32'd4);

    $display("[TB] abort during emit");
    gotBytes.delete(); gotLast.delete();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, fIncr[i], 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b1);
    abortIn  = 1'b0;
    outReady = 1'b0;
    checkOutput("abort_emit_valid", {31'd0, outValid}, 32'd0);
    checkOutput("abort_emit_ready", {31'd0, inReady}, 32'd1);
    checkOutput("abort_emit_cnt", {24'd0, frameCnt}, 32'd4);
    checkOutput("abort_emit_bytes", gotBytes.size(), 32'd2);
    checkOutput("abort_emit_b0", {24'd0, gotBytes[0]}, 32'h08);
    checkOutput("abort_emit_b1", {24'd0, gotBytes[1]}, 32'h86);

    $display("[TB] 256 frames from a fresh reset");
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    for (int k = 0; k < 255; k++) runFrame(fIncr, 1'b0);
    checkOutput("frame_cnt_255", {24'd0, frameCnt}, 32'd255);
    runFrame(fIncr, 1'b0);
    checkOutput("frame_cnt_wrap", {24'd0, frameCnt}, 32'd0);

    $display("[TB] reset mid-emit");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, fOnes[i], 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 1'b1, 1'b0);
    checkOutput("mid_emit_valid", {31'd0, outValid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_in_ready", {31'd0, inReady}, 32'd0);
    checkOutput("async_out_valid", {31'd0, outValid}, 32'd0);
    checkOutput("async_out_byte", {24'd0, outByte}, 32'd0);
    checkOutput("async_out_last", {31'd0, outLast}, 32'd0);
    checkOutput("async_frame_cnt", {24'd0, frameCnt}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("post_reset_ready", {31'd0, inReady}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
